// File: rtl/asmd_run_sequencer.sv
// Initiator for the ASMD start/A/E/F handshake: issues a batch of runs,
// waits for each F rise with a timeout and tallies matching A/E results.
module asmd_run_sequencer #(
  parameter int          RUNW    = 8,
  parameter int          TIMEOUT = 63,
  parameter logic [3:0]  EXP_A   = 4'd13,
  parameter logic        EXP_E   = 1'b1
) (
  input  logic            clk,
  input  logic            rstAL,
  input  logic            req,
  input  logic [RUNW-1:0] numRuns,
  input  logic            abort,
  output logic            start,
  input  logic [3:0]      A_in,
  input  logic            E_in,
  input  logic            F_in,
  output logic            busy,
  output logic            done,
  output logic [RUNW-1:0] runCount,
  output logic [RUNW-1:0] passCount,
  output logic [3:0]      lastA,
  output logic            lastE,
  output logic            errTimeout,
  output logic            errAbort
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK
  } state_t;

  state_t          state;
  state_t          stateNxt;
  logic            fPrev;
  logic            riseF;
  logic [CW-1:0]   waitCnt;
  logic [RUNW-1:0] remaining;

  logic startNxt;
  logic doneNxt;
  logic accept;
  logic capture;
  logic doCheck;
  logic toHit;
  logic abTake;
  logic wInc;
  logic wClr;
  logic match;

  assign riseF = F_in & ~fPrev;
  assign match = (lastA == EXP_A) && (lastE == EXP_E);

  always_comb begin
    stateNxt = state;
    startNxt = 1'b0;
    doneNxt  = 1'b0;
    accept   = 1'b0;
    capture  = 1'b0;
    doCheck  = 1'b0;
    toHit    = 1'b0;
    abTake   = 1'b0;
    wInc     = 1'b0;
    wClr     = 1'b0;
    if (abort && state != IDLE) begin
      stateNxt = IDLE;
      doneNxt  = 1'b1;
      abTake   = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            accept = 1'b1;
            if (numRuns == '0) begin
              doneNxt = 1'b1;
            end else begin
              stateNxt = ISSUE;
              startNxt = 1'b1;
            end
          end
        end
        ISSUE: begin
          wClr     = 1'b1;
          stateNxt = WAIT;
        end
        WAIT: begin
          if (riseF) begin
            capture  = 1'b1;
            stateNxt = CHECK;
          end else if (waitCnt == CW'(TIMEOUT)) begin
            toHit    = 1'b1;
            doneNxt  = 1'b1;
            stateNxt = IDLE;
          end else begin
            wInc = 1'b1;
          end
        end
        CHECK: begin
          doCheck = 1'b1;
          if (remaining <= RUNW'(1)) begin
            doneNxt  = 1'b1;
            stateNxt = IDLE;
          end else begin
            startNxt = 1'b1;
            stateNxt = ISSUE;
          end
        end
        default: stateNxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstAL) begin
    if (!rstAL) begin
      state      <= IDLE;
      fPrev      <= 1'b0;
      start      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      waitCnt    <= '0;
      remaining  <= '0;
      runCount   <= '0;
      passCount  <= '0;
      lastA      <= '0;
      lastE      <= 1'b0;
      errTimeout <= 1'b0;
      errAbort   <= 1'b0;
    end else begin
      state <= stateNxt;
      fPrev <= F_in;
      start <= startNxt;
      busy  <= (stateNxt != IDLE);
      done  <= doneNxt;
      if (wClr) waitCnt <= '0;
      else if (wInc) waitCnt <= waitCnt + CW'(1);
      if (accept) begin
        remaining  <= numRuns;
        runCount   <= '0;
        passCount  <= '0;
        errTimeout <= 1'b0;
        errAbort   <= 1'b0;
      end
      if (capture) begin
        lastA <= A_in;
        lastE <= E_in;
      end
      // counters saturate rather than wrap
      if (doCheck) begin
        remaining <= remaining - RUNW'(1);
        if (runCount != '1) runCount <= runCount + RUNW'(1);
        if (match && passCount != '1)
          passCount <= passCount + RUNW'(1);
      end
      if (toHit) errTimeout <= 1'b1;
      if (abTake) errAbort <= 1'b1;
    end
  end

endmodule

// File: tb/tb_asmd_run_sequencer.sv
// Scoreboard bench for asmd_run_sequencer with a behavioural ASMD unit.
// Expected batch results are queued at request time and popped on done.
module tb_asmd_run_sequencer;

  localparam int RUNW    = 8;
  localparam int TIMEOUT = 63;

  logic            clk = 1'b0;
  logic            rstAL = 1'b0;
  logic            req = 1'b0;
  logic [RUNW-1:0] numRuns = '0;
  logic            abort = 1'b0;
  logic            start;
  logic [3:0]      A_in = 4'd0;
  logic            E_in = 1'b0;
  logic            F_in = 1'b0;
  logic            busy;
  logic            done;
  logic [RUNW-1:0] runCount;
  logic [RUNW-1:0] passCount;
  logic [3:0]      lastA;
  logic            lastE;
  logic            errTimeout;
  logic            errAbort;

  asmd_run_sequencer #(.RUNW(RUNW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstAL(rstAL), .req(req), .numRuns(numRuns),
    .abort(abort), .start(start), .A_in(A_in), .E_in(E_in),
    .F_in(F_in), .busy(busy), .done(done), .runCount(runCount),
    .passCount(passCount), .lastA(lastA), .lastE(lastE),
    .errTimeout(errTimeout), .errAbort(errAbort)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural ASMD unit: F rises a fixed delay after start
  logic hang = 1'b0;
  logic mdlClr = 1'b1;
  int   badRun = 0;
  int   mCnt = 0;
  int   runIdx = 0;
  bit   running = 1'b0;

  always @(posedge clk) begin
    if (mdlClr) begin
      F_in    <= 1'b0;
      running <= 1'b0;
      runIdx  <= 0;
    end else if (start) begin
      F_in    <= 1'b0;
      running <= 1'b1;
      mCnt    <= 5;
      runIdx  <= runIdx + 1;
    end else if (running) begin
      if (mCnt == 0) begin
        running <= 1'b0;
        if (!hang) begin
          F_in <= 1'b1;
          A_in <= (runIdx == badRun) ? 4'd12 : 4'd13;
          E_in <= 1'b1;
        end
      end else begin
        mCnt <= mCnt - 1;
      end
    end
  end

  typedef struct {
    int runs;
    int pass;
    int la;
    int le;
    int errT;
    int errA;
    int starts;
    int lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   nChk = 0;
  int   nPass = 0;
  int   reqCyc = 0;
  int   riseCyc = 0;
  int   abortCyc = 0;
  int   lastStartCyc = 0;
  int   startCnt = 0;
  int   totalStarts = 0;
  bit   firstStart = 1'b0;
  logic prevF = 1'b0;

  function automatic void chk(string nm, int act, int expv);
    nChk++;
    if (act == expv) nPass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endfunction

  always @(negedge clk) begin
    if (rstAL) begin
      if (F_in && !prevF) riseCyc = cyc;
      if (start) begin
        totalStarts++;
        startCnt++;
        if (firstStart) chk("req_to_start", cyc - reqCyc, 1);
        else chk("rise_to_start", cyc - riseCyc, 2);
        firstStart = 1'b0;
        lastStartCyc = cyc;
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("runCount", int'(runCount), e.runs);
          chk("passCount", int'(passCount), e.pass);
          chk("lastA", int'(lastA), e.la);
          chk("lastE", int'(lastE), e.le);
          chk("errTimeout", int'(errTimeout), e.errT);
          chk("errAbort", int'(errAbort), e.errA);
          chk("starts", startCnt, e.starts);
          chk("busy_at_done", int'(busy), 0);
          case (e.lat)
            1: chk("rise_to_done", cyc - riseCyc, 2);
            2: chk("timeout_lat", cyc - lastStartCyc, TIMEOUT + 2);
            3: chk("req_to_done", cyc - reqCyc, 1);
            4: chk("abort_to_done", cyc - abortCyc, 1);
            default: ;
          endcase
        end
        startCnt = 0;
      end
    end
    prevF = F_in;
  end

  task automatic push(int r, int p, int la, int le,
                      int et, int ea, int st, int lat);
    exp_t x;
    x.runs = r; x.pass = p; x.la = la; x.le = le;
    x.errT = et; x.errA = ea; x.starts = st; x.lat = lat;
    sb.push_back(x);
  endtask

  task automatic doReq(int n);
    @(posedge clk); #1;
    numRuns = RUNW'(n);
    req = 1'b1;
    reqCyc = cyc;
    firstStart = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    numRuns = 8'd7;
  endtask

  task automatic waitIdle(string nm);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    chk({nm, "_drained"}, sb.size(), 0);
    sb.delete();
    repeat (4) @(posedge clk);
  endtask

  task automatic mclr();
    @(posedge clk); #1 mdlClr = 1'b1;
    @(posedge clk); #1 mdlClr = 1'b0;
  endtask

  task automatic waitStarts(int base, int n);
    int k;
    k = 0;
    while (totalStarts < base + n && k < 500) begin
      @(posedge clk);
      k++;
    end
    chk("start_wait", int'(totalStarts >= base + n), 1);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_start", int'(start), 0);
    chk("rst_runCount", int'(runCount), 0);
    rstAL = 1'b1;
    mdlClr = 1'b0;
    repeat (2) @(posedge clk);

    push(1, 1, 13, 1, 0, 0, 1, 1);
    doReq(1);
    waitIdle("single");

    mclr();
    push(4, 4, 13, 1, 0, 0, 4, 1);
    doReq(4);
    repeat (10) @(posedge clk);
    #1 req = 1'b1; numRuns = 8'd9;
    @(posedge clk); #1 req = 1'b0;
    waitIdle("four");

    push(0, 0, 13, 1, 0, 0, 0, 3);
    doReq(0);
    waitIdle("zero");

    mclr();
    hang = 1'b1;
    push(0, 0, 13, 1, 1, 0, 1, 2);
    doReq(1);
    waitIdle("timeout");
    hang = 1'b0;

    mclr();
    badRun = 2;
    push(3, 2, 13, 1, 0, 0, 3, 1);
    doReq(3);
    waitIdle("badA");
    badRun = 0;

    mclr();
    base = totalStarts;
    push(1, 1, 13, 1, 0, 1, 2, 4);
    doReq(3);
    waitStarts(base, 2);
    repeat (2) @(posedge clk);
    #1 abort = 1'b1; abortCyc = cyc;
    @(posedge clk); #1 abort = 1'b0;
    repeat (20) @(posedge clk);
    chk("start_after_abort", totalStarts - base, 2);
    waitIdle("abort");

    mclr();
    push(1, 1, 13, 1, 0, 0, 1, 1);
    doReq(1);
    waitIdle("clear_abort");

    mclr();
    base = totalStarts;
    doReq(2);
    waitStarts(base, 1);
    repeat (3) @(posedge clk);
    #1 rstAL = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_lastA", int'(lastA), 0);
    chk("mid_rst_lastE", int'(lastE), 0);
    chk("mid_rst_runCount", int'(runCount), 0);
    chk("mid_rst_passCount", int'(passCount), 0);
    chk("mid_rst_errs", int'({errTimeout, errAbort}), 0);
    @(posedge clk); #1 rstAL = 1'b1;
    repeat (100) @(posedge clk);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_starts", totalStarts - base, 1);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
